// File: rtl/tank_gfx_pkg.sv
// rtl/tank_gfx_pkg.sv - shared tile geometry, colour and coordinate definitions
// Purpose: constants and types shared by the VGA timing block and tile fetchers.
// Contents: tile size, ROM address width, animation frame count/period,
//           transparent colour code, screen coordinate type, tile address helper.
package tank_gfx_pkg;

  localparam int COORD_W     = 10;
  localparam int TILE_W      = 40;
  localparam int TILE_H      = 40;
  localparam int ADDR_W      = 11;
  localparam int LOC_W       = 6;
  localparam int NUM_FRAMES  = 2;
  localparam int ANIM_PERIOD = 30;
  localparam int SEL_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  localparam logic [7:0] TRANSP = 8'h00;

  typedef logic [COORD_W-1:0] coord_t;

  // Row-major tile address; the row stride of 40 is built as 32 + 8 so the
  // stage needs only an adder.
  function automatic logic [ADDR_W-1:0] tile_addr(input logic [LOC_W-1:0] lx,
                                                  input logic [LOC_W-1:0] ly);
    return (ADDR_W'(ly) << 5) + (ADDR_W'(ly) << 3) + ADDR_W'(lx);
  endfunction

endpackage

// File: rtl/water_tile_fetch_anim_seq.sv
// rtl/water_tile_fetch_anim_seq.sv - animation frame sequencer driven by frame ticks
// Purpose: counts frame ticks and advances the animation frame index every
//          PERIOD ticks, wrapping after FRAMES frames.
// Ports: clk, rst (sync active-high), tick (one per video frame),
//        sel (current animation frame index, registered).
module anim_seq #(
  parameter int PERIOD = 30,
  parameter int FRAMES = 2,
  parameter int SEL_W  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  output logic [SEL_W-1:0] sel
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic [SEL_W-1:0] r_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_sel <= '0;
    end else if (tick) begin
      if (r_cnt == CNT_W'(PERIOD - 1)) begin
        r_cnt <= '0;
        r_sel <= (r_sel == SEL_W'(FRAMES - 1)) ? '0 : r_sel + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign sel = r_sel;

endmodule

// File: rtl/water_tile_fetch.sv
// rtl/water_tile_fetch.sv - water tile ROM address/colour pipeline with animation
// Purpose: 3-stage pixel pipeline: in-box test and local coordinates, ROM
//          address, then colour/hit registration; plus animation frame select.
// Ports: clk, rst (sync active-high); pix_valid/pix_x/pix_y current pixel;
//        tile_x/tile_y tile origin; frame_tick per-frame pulse;
//        rom_addr/rom_sel to tile ROMs, rom_data back;
//        pix_out_valid/pix_hit/pix_out to the compositor.
module water_tile_fetch
  import tank_gfx_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  coord_t            pix_x,
  input  coord_t            pix_y,
  input  coord_t            tile_x,
  input  coord_t            tile_y,
  input  logic              frame_tick,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [SEL_W-1:0]  rom_sel,
  input  logic [7:0]        rom_data,
  output logic              pix_out_valid,
  output logic              pix_hit,
  output logic [7:0]        pix_out
);

  // One extra bit so a tile near the right/bottom screen edge does not wrap.
  localparam logic [COORD_W:0] W_EXT = (COORD_W+1)'(TILE_W);
  localparam logic [COORD_W:0] H_EXT = (COORD_W+1)'(TILE_H);

  logic [COORD_W:0] w_x_end;
  logic [COORD_W:0] w_y_end;
  logic             w_inbox;
  logic             w_hit_next;

  logic              r_v1, r_inbox1;
  logic [LOC_W-1:0]  r_lx, r_ly;
  logic              r_v2, r_inbox2;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_out_valid, r_hit;
  logic [7:0]        r_out;

  assign w_x_end = {1'b0, tile_x} + W_EXT;
  assign w_y_end = {1'b0, tile_y} + H_EXT;
  assign w_inbox = (pix_x >= tile_x) && ({1'b0, pix_x} < w_x_end) &&
                   (pix_y >= tile_y) && ({1'b0, pix_y} < w_y_end);

  assign w_hit_next = r_v2 && r_inbox2 && (rom_data != TRANSP);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1        <= 1'b0;
      r_inbox1    <= 1'b0;
      r_lx        <= '0;
      r_ly        <= '0;
      r_v2        <= 1'b0;
      r_inbox2    <= 1'b0;
      r_rom_addr  <= '0;
      r_out_valid <= 1'b0;
      r_hit       <= 1'b0;
      r_out       <= '0;
    end else begin
      // Stage 1
      r_v1     <= pix_valid;
      r_inbox1 <= pix_valid && w_inbox;
      r_lx     <= LOC_W'(pix_x - tile_x);
      r_ly     <= LOC_W'(pix_y - tile_y);
      // Stage 2: address only moves for valid pixels
      if (r_v1) begin
        r_rom_addr <= r_inbox1 ? tile_addr(r_lx, r_ly) : '0;
      end
      r_v2     <= r_v1;
      r_inbox2 <= r_inbox1;
      // Stage 3
      r_out_valid <= r_v2;
      r_hit       <= w_hit_next;
      r_out       <= w_hit_next ? rom_data : 8'h00;
    end
  end

  anim_seq #(
    .PERIOD (ANIM_PERIOD),
    .FRAMES (NUM_FRAMES),
    .SEL_W  (SEL_W)
  ) u_anim_seq (
    .clk  (clk),
    .rst  (rst),
    .tick (frame_tick),
    .sel  (rom_sel)
  );

  assign rom_addr      = r_rom_addr;
  assign pix_out_valid = r_out_valid;
  assign pix_hit       = r_hit;
  assign pix_out       = r_out;

endmodule

// File: tb/tb_water_tile_fetch.sv
// tb/tb_water_tile_fetch.sv - scoreboard bench for water_tile_fetch
module tb_water_tile_fetch;
  import tank_gfx_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              pix_valid;
  coord_t            pix_x, pix_y, tile_x, tile_y;
  logic              frame_tick;
  logic [ADDR_W-1:0] rom_addr;
  logic [SEL_W-1:0]  rom_sel;
  logic [7:0]        rom_data;
  logic              pix_out_valid, pix_hit;
  logic [7:0]        pix_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       hit;
    logic [7:0] out;
    logic [7:0] id;
  } pix_exp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        id;
  } addr_exp_t;

  pix_exp_t  q_pix[$];
  addr_exp_t q_addr[$];

  // Bench-side record of when it drove valid pixels (independent of the DUT).
  logic a1 = 1'b0, a2 = 1'b0, a3 = 1'b0;

  always #5 clk = ~clk;

  water_tile_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid     (pix_valid),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .tile_x        (tile_x),
    .tile_y        (tile_y),
    .frame_tick    (frame_tick),
    .rom_addr      (rom_addr),
    .rom_sel       (rom_sel),
    .rom_data      (rom_data),
    .pix_out_valid (pix_out_valid),
    .pix_hit       (pix_hit),
    .pix_out       (pix_out)
  );

  // Tile ROM model: a few hand-placed bytes in frame 0, otherwise a pattern
  // that is never transparent and differs between frames.
  function automatic logic [7:0] rom_byte(input logic [SEL_W-1:0] sel,
                                          input logic [ADDR_W-1:0] addr);
    if (addr == 11'd5) return 8'h00;
    if (addr == 11'd6) return 8'hFF;
    if (sel == '0 && (addr == 11'd0 || addr == 11'd1599)) return 8'h3C;
    return (8'h80 | {1'b0, addr[6:0]}) ^ ((sel != '0) ? 8'h40 : 8'h00);
  endfunction

  assign rom_data = rom_byte(rom_sel, rom_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      a1 <= 1'b0; a2 <= 1'b0; a3 <= 1'b0;
    end else begin
      a1 <= pix_valid; a2 <= a1; a3 <= a2;
    end
  end

  // Monitor: pops expectations as the DUT presents results.
  always @(negedge clk) begin
    if (!rst && a2) begin
      if (q_addr.size() == 0) begin
        chk("addr_queue_empty", 32'd1, 32'd0);
      end else begin
        addr_exp_t ea;
        ea = q_addr.pop_front();
        chk($sformatf("rom_addr[id%0d]", ea.id), 32'(rom_addr), 32'(ea.addr));
      end
    end
    if (!rst && (pix_out_valid || a3)) begin
      chk("latency_valid", 32'(pix_out_valid), 32'(a3));
      if (q_pix.size() == 0) begin
        chk("pix_queue_empty", 32'd1, 32'd0);
      end else begin
        pix_exp_t ep;
        ep = q_pix.pop_front();
        chk($sformatf("pix_hit[id%0d]", ep.id), 32'(pix_hit), 32'(ep.hit));
        chk($sformatf("pix_out[id%0d]", ep.id), 32'(pix_out), 32'(ep.out));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input int x, input int y, input logic inbox,
                          input int addr, input logic [SEL_W-1:0] frame,
                          input logic tick, input int id);
    logic [7:0] b;
    pix_valid  = 1'b1;
    pix_x      = coord_t'(x);
    pix_y      = coord_t'(y);
    frame_tick = tick;
    b = rom_byte(frame, ADDR_W'(addr));
    q_addr.push_back('{addr: inbox ? ADDR_W'(addr) : '0, id: 8'(id)});
    q_pix.push_back('{hit: inbox && (b != 8'h00),
                      out: (inbox && (b != 8'h00)) ? b : 8'h00, id: 8'(id)});
    step();
    pix_valid  = 1'b0;
    frame_tick = 1'b0;
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((q_pix.size() != 0 || q_addr.size() != 0) && n < 20) begin
      step();
      n++;
    end
    chk("drain_pix_queue", 32'(q_pix.size()), 32'd0);
    step();
  endtask

  initial begin
    // Reset with random inputs
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pix_valid  = 1'($urandom);
      pix_x      = coord_t'($urandom);
      pix_y      = coord_t'($urandom);
      tile_x     = coord_t'($urandom);
      tile_y     = coord_t'($urandom);
      frame_tick = 1'($urandom);
      step();
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      chk("rst_rom_sel", 32'(rom_sel), 32'd0);
      chk("rst_out_valid", 32'(pix_out_valid), 32'd0);
      chk("rst_hit", 32'(pix_hit), 32'd0);
      chk("rst_out", 32'(pix_out), 32'd0);
    end
    rst = 1'b0;
    pix_valid = 1'b0;
    frame_tick = 1'b0;
    tile_x = 10'd100;
    tile_y = 10'd50;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_out_valid", 32'(pix_out_valid), 32'd0);
    end

    // Corners, outside edges, transparency (back-to-back stream)
    send_pix(100, 50, 1'b1, 0,    1'b0, 1'b0, 1);
    send_pix(139, 89, 1'b1, 1599, 1'b0, 1'b0, 2);
    send_pix(140, 50, 1'b0, 0,    1'b0, 1'b0, 3);
    send_pix(99,  50, 1'b0, 0,    1'b0, 1'b0, 4);
    send_pix(105, 50, 1'b1, 5,    1'b0, 1'b0, 5);
    send_pix(106, 50, 1'b1, 6,    1'b0, 1'b0, 6);
    send_pix(100, 90, 1'b0, 0,    1'b0, 1'b0, 7);
    drain();

    // Screen-edge tiles
    tile_x = 10'd620;
    send_pix(639, 52, 1'b1, 99, 1'b0, 1'b0, 8);
    tile_x = 10'd1000;
    send_pix(5,    52, 1'b0, 0,   1'b0, 1'b0, 9);
    send_pix(1010, 52, 1'b1, 90, 1'b0, 1'b0, 10);
    drain();

    // Animation: 29 ticks stay on frame 0
    tile_x = 10'd100;
    pulse_ticks(29);
    chk("sel_after_29", 32'(rom_sel), 32'd0);
    // 30th tick coincides with the 4th pixel of a stream; pixels sampled
    // from one cycle before the tick onward read the new frame.
    for (int i = 0; i < 6; i++) begin
      send_pix(110 + i, 60, 1'b1, 410 + i, (i >= 2) ? 1'b1 : 1'b0, (i == 3), 20 + i);
    end
    drain();
    chk("sel_after_30", 32'(rom_sel), 32'd1);
    send_pix(139, 89, 1'b1, 1599, 1'b1, 1'b0, 30);
    drain();
    pulse_ticks(29);
    chk("sel_after_59", 32'(rom_sel), 32'd1);
    pulse_ticks(1);
    chk("sel_after_60", 32'(rom_sel), 32'd0);
    send_pix(100, 50, 1'b1, 0, 1'b0, 1'b0, 31);
    drain();

    // Mid-stream reset discards in-flight pixels
    pix_valid = 1'b1;
    pix_x = 10'd101;
    pix_y = 10'd51;
    step();
    step();
    rst = 1'b1;
    pix_valid = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(pix_out_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midrst_idle_valid", 32'(pix_out_valid), 32'd0);
    end
    chk("midrst_sel", 32'(rom_sel), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
